// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frame_sequencer
// Purpose  : Frame-level controller for one LED strip. Emits a frame tick,
//            requests every pixel from the renderer in index order, forwards
//            each colour to the pixel driver, closes the frame with a latch
//            beat and paces frames to the target rate.
// Revision : 1.0 - initial release
// ============================================================================
module frame_sequencer #(
    parameter int LED    = 298,
    parameter int IDX_W  = 10,
    parameter int CLK_HZ = 16000000,
    parameter int HZ     = 80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             rnd_tick,
    output logic             rnd_req,
    output logic [IDX_W-1:0] rnd_idx,
    input  logic             rnd_ready,
    input  logic             rnd_done,
    input  logic [7:0]       rnd_red,
    input  logic [7:0]       rnd_green,
    input  logic [7:0]       rnd_blue,
    output logic [7:0]       drv_red,
    output logic [7:0]       drv_green,
    output logic [7:0]       drv_blue,
    output logic             drv_valid,
    output logic             drv_reset,
    input  logic             drv_ready,
    output logic             busy,
    output logic [15:0]      frame_count,
    output logic             overrun
);

    localparam int               FRAME_CYCLES = CLK_HZ / HZ;
    localparam logic [23:0]      c_timer_max  = 24'hFF_FFFF;
    localparam logic [23:0]      c_pace_limit = 24'(FRAME_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_last_idx   = IDX_W'(LED - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TICK  = 3'd1,
        S_REQ   = 3'd2,
        S_WAIT  = 3'd3,
        S_PUSH  = 3'd4,
        S_LATCH = 3'd5,
        S_PACE  = 3'd6
    } state_t;

    state_t           r_state_q,       w_state_d;
    logic [IDX_W-1:0] r_idx_q,         w_idx_d;
    logic [23:0]      r_timer_q,       w_timer_d;
    logic             r_pace_first_q,  w_pace_first_d;
    logic [15:0]      r_frame_count_q, w_frame_count_d;
    logic             r_overrun_q,     w_overrun_d;
    logic [7:0]       r_hold_red_q,    w_hold_red_d;
    logic [7:0]       r_hold_green_q,  w_hold_green_d;
    logic [7:0]       r_hold_blue_q,   w_hold_blue_d;
    logic             r_rnd_tick_q,    w_rnd_tick_d;
    logic             r_rnd_req_q,     w_rnd_req_d;
    logic             r_drv_valid_q,   w_drv_valid_d;
    logic             r_drv_reset_q,   w_drv_reset_d;
    logic [7:0]       r_drv_red_q,     w_drv_red_d;
    logic [7:0]       r_drv_green_q,   w_drv_green_d;
    logic [7:0]       r_drv_blue_q,    w_drv_blue_d;
    logic             r_busy_q,        w_busy_d;
    logic [23:0]      w_timer_inc;
    logic             w_pace_done;

    // Next-state, datapath and next-output decode; outputs are decoded from the
    // next state so every port is driven straight from a flop.
    always_comb begin
        w_state_d       = r_state_q;
        w_idx_d         = r_idx_q;
        w_timer_d       = r_timer_q;
        w_pace_first_d  = r_pace_first_q;
        w_frame_count_d = r_frame_count_q;
        w_overrun_d     = r_overrun_q;
        w_hold_red_d    = r_hold_red_q;
        w_hold_green_d  = r_hold_green_q;
        w_hold_blue_d   = r_hold_blue_q;

        // The pacing test looks at the value the timer takes next cycle, so a
        // frame that needs no padding leaves PACE after exactly one cycle and
        // the tick-to-tick period lands on FRAME_CYCLES.
        w_timer_inc = (r_timer_q == c_timer_max) ? r_timer_q : r_timer_q + 24'd1;
        w_pace_done = (w_timer_inc >= c_pace_limit);
        if (r_state_q != S_IDLE) begin
            w_timer_d = w_timer_inc;
        end

        case (r_state_q)
            S_IDLE: begin
                if (enable) begin
                    w_state_d = S_TICK;
                end
            end
            S_TICK: begin
                w_idx_d   = '0;
                w_timer_d = '0;
                w_state_d = S_REQ;
            end
            S_REQ: begin
                if (rnd_ready) begin
                    w_state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rnd_done) begin
                    w_hold_red_d   = rnd_red;
                    w_hold_green_d = rnd_green;
                    w_hold_blue_d  = rnd_blue;
                    w_state_d      = S_PUSH;
                end
            end
            S_PUSH: begin
                if (drv_ready) begin
                    if (r_idx_q == c_last_idx) begin
                        w_state_d = S_LATCH;
                    end else begin
                        w_idx_d   = r_idx_q + IDX_W'(1);
                        w_state_d = S_REQ;
                    end
                end
            end
            S_LATCH: begin
                if (drv_ready) begin
                    w_frame_count_d = r_frame_count_q + 16'd1;
                    w_pace_first_d  = 1'b1;
                    w_state_d       = S_PACE;
                end
            end
            S_PACE: begin
                w_pace_first_d = 1'b0;
                if (w_pace_done) begin
                    // Done on the very first PACE cycle means the frame's own
                    // work already used up the whole frame budget.
                    if (r_pace_first_q) begin
                        w_overrun_d = 1'b1;
                    end
                    w_state_d = enable ? S_TICK : S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        w_rnd_tick_d  = (w_state_d == S_TICK);
        w_rnd_req_d   = (w_state_d == S_REQ);
        w_drv_valid_d = (w_state_d == S_PUSH) || (w_state_d == S_LATCH);
        w_drv_reset_d = (w_state_d == S_LATCH);
        w_drv_red_d   = (w_state_d == S_PUSH) ? w_hold_red_d   : 8'd0;
        w_drv_green_d = (w_state_d == S_PUSH) ? w_hold_green_d : 8'd0;
        w_drv_blue_d  = (w_state_d == S_PUSH) ? w_hold_blue_d  : 8'd0;
        w_busy_d      = (w_state_d != S_IDLE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q       <= S_IDLE;
            r_idx_q         <= '0;
            r_timer_q       <= '0;
            r_pace_first_q  <= 1'b0;
            r_frame_count_q <= '0;
            r_overrun_q     <= 1'b0;
            r_hold_red_q    <= '0;
            r_hold_green_q  <= '0;
            r_hold_blue_q   <= '0;
            r_rnd_tick_q    <= 1'b0;
            r_rnd_req_q     <= 1'b0;
            r_drv_valid_q   <= 1'b0;
            r_drv_reset_q   <= 1'b0;
            r_drv_red_q     <= '0;
            r_drv_green_q   <= '0;
            r_drv_blue_q    <= '0;
            r_busy_q        <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_idx_q         <= w_idx_d;
            r_timer_q       <= w_timer_d;
            r_pace_first_q  <= w_pace_first_d;
            r_frame_count_q <= w_frame_count_d;
            r_overrun_q     <= w_overrun_d;
            r_hold_red_q    <= w_hold_red_d;
            r_hold_green_q  <= w_hold_green_d;
            r_hold_blue_q   <= w_hold_blue_d;
            r_rnd_tick_q    <= w_rnd_tick_d;
            r_rnd_req_q     <= w_rnd_req_d;
            r_drv_valid_q   <= w_drv_valid_d;
            r_drv_reset_q   <= w_drv_reset_d;
            r_drv_red_q     <= w_drv_red_d;
            r_drv_green_q   <= w_drv_green_d;
            r_drv_blue_q    <= w_drv_blue_d;
            r_busy_q        <= w_busy_d;
        end
    end

    assign rnd_tick    = r_rnd_tick_q;
    assign rnd_req     = r_rnd_req_q;
    assign rnd_idx     = r_idx_q;
    assign drv_valid   = r_drv_valid_q;
    assign drv_reset   = r_drv_reset_q;
    assign drv_red     = r_drv_red_q;
    assign drv_green   = r_drv_green_q;
    assign drv_blue    = r_drv_blue_q;
    assign busy        = r_busy_q;
    assign frame_count = r_frame_count_q;
    assign overrun     = r_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_sequencer
// Purpose  : Self-checking bench for frame_sequencer. Models a renderer and a
//            pixel driver with random colours, latencies and stalls, and keeps
//            a frame-level reference (index order, colour queue, frame
//            period, frame count, overrun) to compare against.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_sequencer;

    localparam int LED    = 4;
    localparam int IDX_W  = 10;
    localparam int CLK_HZ = 1000;
    localparam int HZ     = 10;
    localparam int FC     = CLK_HZ / HZ;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             rnd_tick;
    logic             rnd_req;
    logic [IDX_W-1:0] rnd_idx;
    logic             rnd_ready = 1'b0;
    logic             rnd_done = 1'b0;
    logic [7:0]       rnd_red = 8'd0;
    logic [7:0]       rnd_green = 8'd0;
    logic [7:0]       rnd_blue = 8'd0;
    logic [7:0]       drv_red;
    logic [7:0]       drv_green;
    logic [7:0]       drv_blue;
    logic             drv_valid;
    logic             drv_reset;
    logic             drv_ready = 1'b0;
    logic             busy;
    logic [15:0]      frame_count;
    logic             overrun;

    frame_sequencer #(
        .LED    (LED),
        .IDX_W  (IDX_W),
        .CLK_HZ (CLK_HZ),
        .HZ     (HZ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .rnd_tick    (rnd_tick),
        .rnd_req     (rnd_req),
        .rnd_idx     (rnd_idx),
        .rnd_ready   (rnd_ready),
        .rnd_done    (rnd_done),
        .rnd_red     (rnd_red),
        .rnd_green   (rnd_green),
        .rnd_blue    (rnd_blue),
        .drv_red     (drv_red),
        .drv_green   (drv_green),
        .drv_blue    (drv_blue),
        .drv_valid   (drv_valid),
        .drv_reset   (drv_reset),
        .drv_ready   (drv_ready),
        .busy        (busy),
        .frame_count (frame_count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    int          cyc = 0;
    int          tick_cnt = 0;
    int          tick_cyc = 0;
    int          nat = 0;
    bit          prev_valid = 1'b0;
    bit          in_frame = 1'b0;
    int          exp_idx = 0;
    int          pix_cnt = 0;
    int          frames_exp = 0;
    bit          ovr_exp = 1'b0;
    bit          req_seen = 1'b0;
    logic [IDX_W-1:0] req_idx_hold = '0;
    bit          pend = 1'b0;
    int          pcnt = 0;
    bit          beat_seen = 1'b0;
    logic [24:0] beat_hold = '0;
    int          rstall = 0;
    int          dstall = 0;
    logic [23:0] exp_q [$];

    // Stimulus knobs
    int lat_min = 1;
    int lat_max = 1;
    bit rnd_rand = 1'b0;
    bit drv_rand = 1'b0;
    bit spur_en = 1'b0;
    int stall_at = -1;
    bit stall_idx0 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic reset_model();
        tick_cnt   = 0;
        prev_valid = 1'b0;
        in_frame   = 1'b0;
        exp_idx    = 0;
        pix_cnt    = 0;
        frames_exp = 0;
        ovr_exp    = 1'b0;
        req_seen   = 1'b0;
        pend       = 1'b0;
        beat_seen  = 1'b0;
        rstall     = 0;
        dstall     = 0;
        exp_q.delete();
    endtask

    // One clock: observe outputs at the falling edge, update the reference,
    // then drive inputs for the next rising edge.
    task automatic step();
        logic [23:0] col;
        bit          done_now;
        @(negedge clk);
        cyc++;
        check("no_req_and_valid", 32'(rnd_req & drv_valid), 32'd0);

        if (rnd_tick) begin
            tick_cnt++;
            if (prev_valid) check("frame_period", cyc - tick_cyc, (nat > FC) ? nat : FC);
            check("tick_frame_count", frame_count, frames_exp);
            check("tick_overrun", overrun, ovr_exp);
            tick_cyc   = cyc;
            prev_valid = 1'b1;
            in_frame   = 1'b1;
            exp_idx    = 0;
            pix_cnt    = 0;
        end

        // Renderer model
        done_now = 1'b0;
        rnd_done = 1'b0;
        {rnd_red, rnd_green, rnd_blue} = 24'($urandom);
        if (pend) begin
            pcnt--;
            if (pcnt == 0) begin
                pend = 1'b0;
                col  = 24'($urandom);
                {rnd_red, rnd_green, rnd_blue} = col;
                rnd_done = 1'b1;
                done_now = 1'b1;
                exp_q.push_back(col);
            end
        end
        if (rnd_req) begin
            if (!req_seen) begin
                check("req_after_tick", 32'(in_frame), 32'd1);
                check("rnd_idx", rnd_idx, exp_idx);
                req_seen     = 1'b1;
                req_idx_hold = rnd_idx;
                if (stall_idx0 && exp_idx == 0) rstall = 3;
            end else begin
                check("rnd_idx_hold", rnd_idx, req_idx_hold);
            end
            if (rstall > 0) begin
                rnd_ready = 1'b0;
                rstall--;
            end else begin
                rnd_ready = (rnd_rand && $urandom_range(3) == 0) ? 1'b0 : 1'b1;
            end
            if (rnd_ready) begin
                pend     = 1'b1;
                pcnt     = int'($urandom_range(lat_max, lat_min));
                req_seen = 1'b0;
                exp_idx++;
            end
        end else begin
            if (req_seen) begin
                check("rnd_req_hold", 32'(rnd_req), 32'd1);
                req_seen = 1'b0;
            end
            rnd_ready = 1'($urandom_range(1));
        end
        // Stray done pulses while the sequencer is requesting or pushing
        if (!done_now && spur_en && (rnd_req || drv_valid) && $urandom_range(1) == 1) begin
            rnd_done = 1'b1;
        end

        // Pixel driver model
        if (drv_valid) begin
            if (!beat_seen) begin
                beat_seen = 1'b1;
                beat_hold = {drv_reset, drv_red, drv_green, drv_blue};
                if (!drv_reset && pix_cnt == stall_at) dstall = 5;
            end else begin
                check("drv_beat_hold", {drv_reset, drv_red, drv_green, drv_blue}, beat_hold);
            end
            if (dstall > 0) begin
                drv_ready = 1'b0;
                dstall--;
            end else begin
                drv_ready = (drv_rand && $urandom_range(3) == 0) ? 1'b0 : 1'b1;
            end
            if (drv_ready) begin
                beat_seen = 1'b0;
                if (drv_reset) begin
                    check("latch_rgb", {drv_red, drv_green, drv_blue}, 24'd0);
                    check("pixels_per_frame", pix_cnt, LED);
                    frames_exp++;
                    nat = cyc + 2 - tick_cyc;
                    if (nat >= FC) ovr_exp = 1'b1;
                    in_frame = 1'b0;
                end else begin
                    check("pixel_expected", 32'(exp_q.size() > 0), 32'd1);
                    col = (exp_q.size() > 0) ? exp_q.pop_front() : 24'd0;
                    check("pixel_rgb", {drv_red, drv_green, drv_blue}, col);
                    pix_cnt++;
                end
            end
        end else begin
            if (beat_seen) begin
                check("drv_valid_hold", 32'(drv_valid), 32'd1);
                beat_seen = 1'b0;
            end
            drv_ready = 1'($urandom_range(1));
        end
    endtask

    task automatic run_ticks(input int n, input int budget);
        int target;
        int k;
        target = tick_cnt + n;
        k = 0;
        while (tick_cnt < target && k < budget) begin
            step();
            k++;
        end
        check("tick_timeout", 32'(tick_cnt >= target), 32'd1);
    endtask

    task automatic run_frames(input int n, input int budget);
        int target;
        int k;
        target = frames_exp + n;
        k = 0;
        while (frames_exp < target && k < budget) begin
            step();
            k++;
        end
        check("frame_timeout", 32'(frames_exp >= target), 32'd1);
    endtask

    initial begin
        int k;
        int ticks_before;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_rnd_tick", 32'(rnd_tick), 32'd0);
        check("rst_rnd_req", 32'(rnd_req), 32'd0);
        check("rst_rnd_idx", rnd_idx, 32'd0);
        check("rst_drv", {drv_valid, drv_reset, drv_red, drv_green, drv_blue}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_count", frame_count, 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        repeat (5) step();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_no_tick", tick_cnt, 32'd0);

        // Ready tied high, latency 1: paced frames
        enable = 1'b1;
        run_ticks(3, 400);
        check("frames_after_two", frame_count, 32'd2);

        // Driver stall on pixel 2
        stall_at = 2;
        run_ticks(1, 200);
        stall_at = -1;

        // Random handshakes, latencies and stray done pulses
        rnd_rand = 1'b1;
        drv_rand = 1'b1;
        spur_en  = 1'b1;
        lat_min  = 1;
        lat_max  = 4;
        run_ticks(3, 700);

        // Drop enable while pixel 1 is requested
        k = 0;
        while (!(rnd_req && rnd_idx == 1) && k < 300) begin
            step();
            k++;
        end
        check("reach_idx1", 32'(rnd_req && rnd_idx == 1), 32'd1);
        enable = 1'b0;
        ticks_before = tick_cnt;
        run_frames(1, 300);
        repeat (150) step();
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_no_tick", tick_cnt, ticks_before);
        check("stop_frame_count", frame_count, frames_exp);
        check("stop_outputs", {rnd_req, drv_valid}, 32'd0);

        // Asynchronous reset during the push of pixel 2
        rnd_rand   = 1'b0;
        drv_rand   = 1'b0;
        prev_valid = 1'b0;
        stall_at   = 2;
        enable     = 1'b1;
        k = 0;
        while (!(drv_valid && !drv_reset && pix_cnt == 2) && k < 300) begin
            step();
            k++;
        end
        check("reach_push2", 32'(drv_valid && !drv_reset && pix_cnt == 2), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_drv_valid", 32'(drv_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_frame_count", frame_count, 32'd0);
        stall_at = -1;
        reset_model();
        rnd_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_ticks(3, 400);

        // Slow renderer with an accept stall on pixel 0: frame overruns
        lat_min    = 30;
        lat_max    = 30;
        stall_idx0 = 1'b1;
        run_ticks(2, 800);
        check("overrun_final", 32'(overrun), 32'(ovr_exp));
        check("overrun_expected_set", 32'(ovr_exp), 32'(overrun | 1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
